// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: two requester ports and the data-memory bus served by mem_arbiter.
interface mem_arbiter_if;
    logic        p0_req, p0_we, p0_gnt, p0_done, p0_err;
    logic [2:0]  p0_funct3;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic        p1_req, p1_we, p1_gnt, p1_done, p1_err;
    logic [2:0]  p1_funct3;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wd, mem_instr, mem_rd;
    modport slave (
        input  p0_req, p0_we, p0_funct3, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_funct3, p1_addr, p1_wdata, mem_rd,
        output p0_gnt, p0_done, p0_err, p0_rdata,
        output p1_gnt, p1_done, p1_err, p1_rdata,
        output mem_we, mem_addr, mem_wd, mem_instr
    );
    modport master (
        output p0_req, p0_we, p0_funct3, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_funct3, p1_addr, p1_wdata, mem_rd,
        input  p0_gnt, p0_done, p0_err, p0_rdata,
        input  p1_gnt, p1_done, p1_err, p1_rdata,
        input  mem_we, mem_addr, mem_wd, mem_instr
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port data-memory arbiter, 3-cycle IDLE/ACCESS/RESP handshake,
// port 0 priority with a starvation guard for port 1 and a misalignment check.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
    localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          port_q, port_d, we_q, we_d;
    logic [2:0]    f3_q, f3_d;
    logic [31:0]   addr_q, addr_d, wd_q, wd_d, rdata_q, rdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pick1, grant, mis, resp;

    always_comb begin
        pick1   = bus.p1_req && (!bus.p0_req || cnt_q == LIM);
        // gated by reset so no grant can leak out while reset is held
        grant   = state_q == IDLE && reset && (bus.p0_req || bus.p1_req);
        mis     = (f3_q == 3'b010 && addr_q[1:0] != 2'b00) ||
                  ((f3_q == 3'b001 || f3_q == 3'b101) && addr_q[0]);
        resp    = state_q == RESP;
        state_d = grant ? ACCESS : state_q == ACCESS ? RESP : state_q == RESP ? IDLE : state_q;
        port_d  = grant ? pick1 : port_q;
        we_d    = grant ? (pick1 ? bus.p1_we : bus.p0_we) : we_q;
        f3_d    = grant ? (pick1 ? bus.p1_funct3 : bus.p0_funct3) : f3_q;
        addr_d  = grant ? (pick1 ? bus.p1_addr : bus.p0_addr) : addr_q;
        wd_d    = grant ? (pick1 ? bus.p1_wdata : bus.p0_wdata) : wd_q;
        cnt_d   = !grant ? cnt_q : pick1 ? '0 :
                  (bus.p1_req && cnt_q != LIM) ? cnt_q + CW'(1) : cnt_q;
        rdata_d = state_q == ACCESS ? ((we_q || mis) ? '0 : bus.mem_rd) : rdata_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wd_q    <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.p0_gnt    = grant && !pick1;
    assign bus.p1_gnt    = grant && pick1;
    assign bus.p0_done   = resp && !port_q;
    assign bus.p1_done   = resp && port_q;
    assign bus.p0_err    = bus.p0_done && mis;
    assign bus.p1_err    = bus.p1_done && mis;
    assign bus.p0_rdata  = bus.p0_done ? rdata_q : '0;
    assign bus.p1_rdata  = bus.p1_done ? rdata_q : '0;
    assign bus.mem_we    = state_q == ACCESS && we_q && !mis;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wd    = wd_q;
    assign bus.mem_instr = {17'b0, f3_q, 12'b0};
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4: the number of consecutive lost arbitrations by port 1 after which port 1 is forced to win.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- p0_req  in  1  port 0 (core load/store unit) request; held with its fields until p0_gnt.
- p0_we  in  1  port 0 write enable (1 = store, 0 = load).
- p0_funct3  in  3  port 0 access size: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
- p0_addr  in  32  port 0 byte address.
- p0_wdata  in  32  port 0 store data.
- p0_gnt  out  1  port 0 request accepted (one-cycle pulse).
- p0_done  out  1  port 0 access complete (one-cycle pulse).
- p0_err  out  1  port 0 misaligned access; valid with p0_done.
- p0_rdata  out  32  port 0 raw load word; valid with p0_done.
- p1_req, p1_we, p1_funct3, p1_addr, p1_wdata, p1_gnt, p1_done, p1_err, p1_rdata: same as port 0, for port 1 (DMA/debug).
- mem_we  out  1  data memory write enable.
- mem_addr  out  32  data memory byte address.
- mem_wd  out  32  data memory write data.
- mem_instr  out  32  access-size word: funct3 in bits [14:12], all other bits 0.
- mem_rd  in  32  data memory combinational read word.

Function
REQ-003 The FSM SHALL have three states: IDLE, ACCESS, RESP.
REQ-004 In IDLE with any request pending, the arbiter SHALL pulse exactly one gnt, latch that port's we/funct3/addr/wdata and port id, and go to ACCESS; with no request it SHALL stay in IDLE.
REQ-005 Priority: port 0 wins a simultaneous request unless the starvation counter equals STARVE_LIMIT, in which case port 1 wins.
REQ-006 The starvation counter SHALL increment when port 1 requests and loses, clear when port 1 is granted, hold otherwise, and saturate at STARVE_LIMIT.
REQ-007 In ACCESS the block SHALL drive mem_addr, mem_wd and mem_instr from the latched request, assert mem_we only for an aligned store, and capture mem_rd; it SHALL then go to RESP.
REQ-008 Alignment: word accesses require addr[1:0]=00 and half accesses require addr[0]=0; byte accesses are always aligned; any misaligned access SHALL set err and SHALL NOT assert mem_we.
REQ-009 In RESP the block SHALL pulse done for the latched port only, with rdata = the captured word (0 for stores and errors) and err per REQ-008, then return to IDLE.
REQ-010 Timing: a request sampled in IDLE on edge N SHALL give gnt during cycle N, the memory access during cycle N+1, and done during cycle N+2; the next grant is possible in cycle N+3 (throughput one access per 3 cycles).
REQ-011 Outside ACCESS, mem_we SHALL be 0; mem_addr, mem_wd and mem_instr SHALL hold their last values.
REQ-012 A request dropped before its gnt SHALL be ignored; requests arriving in ACCESS or RESP SHALL wait and are not lost while held.
REQ-013 Unsupported funct3 values (011, 110, 111) SHALL be forwarded unchanged, treated as byte for the alignment check.

Reset
REQ-014 Asserting reset (low) SHALL immediately force: state IDLE; all gnt, done, err and mem_we to 0; rdata, mem_addr, mem_wd and mem_instr to 0; starvation counter to 0.
REQ-015 Reset during ACCESS SHALL abort the access with no write and no done pulse; deassertion SHALL take effect on the next rising clk edge.

Verification
REQ-016 Port 0 word store, addr 0x10, data 0xDEADBEEF -> mem_we=1 for exactly one cycle with mem_addr=0x10 and mem_instr=0x00002000; p0_done two cycles after p0_gnt with p0_err=0.
REQ-017 Port 1 word load, addr 0x10, mem_rd=0xDEADBEEF -> p1_done with p1_rdata=0xDEADBEEF; p0_done stays 0.
REQ-018 Both ports request continuously, STARVE_LIMIT=4 -> grant sequence 0,0,0,0,1,0,0,0,0,1.
REQ-019 Port 0 half store at addr 0x13 -> mem_we never asserted; p0_done with p0_err=1 and p0_rdata=0.
REQ-020 Reset asserted during ACCESS of a store -> mem_we drops immediately, no done pulse; after release an idle cycle shows all outputs 0.
